axum_wb_arbiter: RTL and testbench

//  Writeback arbiter/staging stage directly upstream of the integer register file's single write

---
 rtl/axum_wb_arbiter_if.sv | 37 +++
 rtl/axum_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_axum_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axum_wb_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axum_wb_arbiter_if : EX/LSU result inputs and register-file write port       |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
interface axum_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                  ex_valid_i;
    logic [4:0]            ex_waddr_i;
    logic [DATA_WIDTH-1:0] ex_wdata_i;
    logic                  lsu_valid_i;
    logic                  lsu_ready_o;
    logic [4:0]            lsu_waddr_i;
    logic [DATA_WIDTH-1:0] lsu_wdata_i;
    logic [4:0]            waddr_a_o;
    logic [DATA_WIDTH-1:0] wdata_a_o;
    logic                  we_a_o;
    logic [31:0]           pending_o;
    logic [c_CNT_W-1:0]    fifo_count_o;

    modport slave (
        input  ex_valid_i, ex_waddr_i, ex_wdata_i,
        input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        output lsu_ready_o, waddr_a_o, wdata_a_o, we_a_o, pending_o, fifo_count_o
    );

    modport master (
        output ex_valid_i, ex_waddr_i, ex_wdata_i,
        output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        input  lsu_ready_o, waddr_a_o, wdata_a_o, we_a_o, pending_o, fifo_count_o
    );
endinterface
`default_nettype wire

// File: rtl/axum_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axum_wb_arbiter : merges EX and queued LSU results into one registered       |
// | register-file write per cycle; stale queued results are killed.               |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module axum_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2,
    parameter bit RV32E      = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    axum_wb_arbiter_if.slave  bus
);
    localparam int                 c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                 c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(FIFO_DEPTH);

    logic [4:0]            r_q_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_q_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_q_live;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_we;
    logic [4:0]            r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic [4:0]            w_ex_addr;
    logic [4:0]            w_lsu_addr;
    logic                  w_ex_wr;
    logic                  w_lsu_ready;
    logic                  w_lsu_wr;
    logic                  w_empty;
    logic                  w_sel_pop;
    logic                  w_sel_byp;
    logic                  w_push;
    logic                  w_push_live;
    logic                  w_head_live;
    logic [c_PTR_W-1:0]    w_rd_next;
    logic [c_PTR_W-1:0]    w_wr_next;
    logic [31:0]           w_pending;

    assign w_ex_addr   = RV32E ? {1'b0, bus.ex_waddr_i[3:0]}  : bus.ex_waddr_i;
    assign w_lsu_addr  = RV32E ? {1'b0, bus.lsu_waddr_i[3:0]} : bus.lsu_waddr_i;

    assign w_lsu_ready = (r_count < c_FULL);
    assign w_ex_wr     = bus.ex_valid_i && (w_ex_addr != 5'd0);
    assign w_lsu_wr    = bus.lsu_valid_i && w_lsu_ready && (w_lsu_addr != 5'd0);
    assign w_empty     = (r_count == '0);

    // EX always wins; the queue drains before any new LSU result may bypass it.
    assign w_sel_pop   = !w_ex_wr && !w_empty;
    assign w_sel_byp   = !w_ex_wr && w_empty && w_lsu_wr;
    assign w_push      = w_lsu_wr && !w_sel_byp;
    // A same-cycle EX write to the same register is younger, so the LSU result is born dead.
    assign w_push_live = !(w_ex_wr && (w_lsu_addr == w_ex_addr));
    assign w_head_live = r_q_live[r_rd_ptr];

    assign w_rd_next   = (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
    assign w_wr_next   = (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_q_live[i]) begin
                w_pending[r_q_addr[i]] = 1'b1;
            end
        end
        if (r_we) begin
            w_pending[r_waddr] = 1'b1;
        end
        w_pending[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q_live <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (w_ex_wr && (r_q_addr[i] == w_ex_addr)) begin
                    r_q_live[i] <= 1'b0;
                end
            end
            if (w_sel_pop) begin
                r_q_live[r_rd_ptr] <= 1'b0;
                r_rd_ptr           <= w_rd_next;
            end
            if (w_push) begin
                r_q_live[r_wr_ptr] <= w_push_live;
                r_wr_ptr           <= w_wr_next;
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_sel_pop);

            r_we <= w_ex_wr || (w_sel_pop && w_head_live) || w_sel_byp;
            if (w_ex_wr) begin
                r_waddr <= w_ex_addr;
                r_wdata <= bus.ex_wdata_i;
            end else if (w_sel_pop && w_head_live) begin
                r_waddr <= r_q_addr[r_rd_ptr];
                r_wdata <= r_q_data[r_rd_ptr];
            end else if (w_sel_byp) begin
                r_waddr <= w_lsu_addr;
                r_wdata <= bus.lsu_wdata_i;
            end
        end
    end

    // Payload needs no reset; occupancy is tracked by the live bits and the count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr] <= w_lsu_addr;
            r_q_data[r_wr_ptr] <= bus.lsu_wdata_i;
        end
    end

    assign bus.lsu_ready_o  = w_lsu_ready;
    assign bus.we_a_o       = r_we;
    assign bus.waddr_a_o    = r_waddr;
    assign bus.wdata_a_o    = r_wdata;
    assign bus.pending_o    = w_pending;
    assign bus.fifo_count_o = r_count;
endmodule
`default_nettype wire

// File: tb/tb_axum_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axum_wb_arbiter : scoreboard bench for the writeback arbiter              |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_axum_wb_arbiter;
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;

    always #5 clk = ~clk;

    axum_wb_arbiter_if #(.DATA_WIDTH(32), .FIFO_DEPTH(2)) bus ();

    axum_wb_arbiter #(.DATA_WIDTH(32), .FIFO_DEPTH(2), .RV32E(1'b0)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    // Every issued write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.we_a_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected got x%0d=%h required none", bus.waddr_a_o, bus.wdata_a_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.waddr_a_o !== mon_e.a || bus.wdata_a_o !== mon_e.d) begin
                    bad++;
                    $display("FAIL write_data got x%0d=%h required x%0d=%h",
                             bus.waddr_a_o, bus.wdata_a_o, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive_ex(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.ex_valid_i = v;
        bus.ex_waddr_i = a;
        bus.ex_wdata_i = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.lsu_valid_i = v;
        bus.lsu_waddr_i = a;
        bus.lsu_wdata_i = d;
    endtask

    task automatic idle();
        drive_ex(1'b0, 5'd0, 32'd0);
        drive_lsu(1'b0, 5'd0, 32'd0);
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        idle();
        #1;
        total++;
        if (bus.we_a_o !== 1'b0 || bus.waddr_a_o !== 5'd0 || bus.wdata_a_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_out got we=%b a=%0d d=%h required 0/0/0", bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o);
        end
        total++;
        if (bus.fifo_count_o !== 2'd0 || bus.pending_o !== 32'd0 || bus.lsu_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_state got cnt=%0d pend=%h rdy=%b required 0/0/1",
                     bus.fifo_count_o, bus.pending_o, bus.lsu_ready_o);
        end
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_ex_only();
        drive_ex(1'b1, 5'd5, 32'hA5A5_0001);
        push_exp(5'd5, 32'hA5A5_0001);
        cyc();
        idle();
        total++;
        if (bus.we_a_o !== 1'b1 || bus.waddr_a_o !== 5'd5 || bus.pending_o !== 32'h20) begin
            bad++;
            $display("FAIL ex_latency got we=%b a=%0d pend=%h required 1/5/00000020",
                     bus.we_a_o, bus.waddr_a_o, bus.pending_o);
        end
        cyc();
        total++;
        if (bus.we_a_o !== 1'b0 || bus.pending_o !== 32'd0) begin
            bad++;
            $display("FAIL ex_idle got we=%b pend=%h required 0/0", bus.we_a_o, bus.pending_o);
        end
    endtask

    task automatic test_bypass();
        drive_lsu(1'b1, 5'd7, 32'h1234);
        push_exp(5'd7, 32'h1234);
        total++;
        if (bus.lsu_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL bypass_ready got %b required 1", bus.lsu_ready_o);
        end
        cyc();
        idle();
        total++;
        if (bus.we_a_o !== 1'b1 || bus.waddr_a_o !== 5'd7 || bus.fifo_count_o !== 2'd0) begin
            bad++;
            $display("FAIL bypass got we=%b a=%0d cnt=%0d required 1/7/0",
                     bus.we_a_o, bus.waddr_a_o, bus.fifo_count_o);
        end
        cyc();
    endtask

    task automatic test_queue_full();
        int  li;
        logic acc;
        li = 0;
        for (int i = 0; i < 4; i++) push_exp(5'(i + 1), 32'h100 + 32'(i));
        for (int i = 0; i < 3; i++) push_exp(5'(8 + i), 32'h800 + 32'(i));
        for (int c = 0; c < 9; c++) begin
            drive_ex(c < 4, (c < 4) ? 5'(c + 1) : 5'd0, 32'h100 + 32'(c));
            drive_lsu(li < 3, (li < 3) ? 5'(8 + li) : 5'd0, 32'h800 + 32'(li));
            acc = bus.lsu_valid_i && bus.lsu_ready_o;
            if (c == 2) begin
                total++;
                if (bus.fifo_count_o !== 2'd2 || bus.lsu_ready_o !== 1'b0) begin
                    bad++;
                    $display("FAIL queue_full got cnt=%0d rdy=%b required 2/0", bus.fifo_count_o, bus.lsu_ready_o);
                end
            end
            cyc();
            if (acc) li++;
            if (c >= 4 && c <= 6) begin
                total++;
                if (bus.we_a_o !== 1'b1 || bus.waddr_a_o !== 5'(4 + c)) begin
                    bad++;
                    $display("FAIL queue_drain c=%0d got we=%b a=%0d required 1/%0d", c, bus.we_a_o, bus.waddr_a_o, 4 + c);
                end
            end
        end
        idle();
        total++;
        if (li != 3 || bus.fifo_count_o !== 2'd0) begin
            bad++;
            $display("FAIL queue_end got accepted=%0d cnt=%0d required 3/0", li, bus.fifo_count_o);
        end
    endtask

    task automatic test_kill();
        drive_ex(1'b1, 5'd3, 32'h33);
        drive_lsu(1'b1, 5'd9, 32'h11);
        push_exp(5'd3, 32'h33);
        cyc();
        total++;
        if (bus.fifo_count_o !== 2'd1 || bus.pending_o !== 32'h208) begin
            bad++;
            $display("FAIL kill_queued got cnt=%0d pend=%h required 1/00000208", bus.fifo_count_o, bus.pending_o);
        end
        drive_ex(1'b1, 5'd9, 32'h22);
        drive_lsu(1'b0, 5'd0, 32'd0);
        push_exp(5'd9, 32'h22);
        cyc();
        idle();
        total++;
        if (bus.fifo_count_o !== 2'd1 || bus.pending_o !== 32'h200) begin
            bad++;
            $display("FAIL kill_pending got cnt=%0d pend=%h required 1/00000200", bus.fifo_count_o, bus.pending_o);
        end
        cyc();
        total++;
        if (bus.we_a_o !== 1'b0 || bus.fifo_count_o !== 2'd0 || bus.pending_o !== 32'd0) begin
            bad++;
            $display("FAIL kill_pop got we=%b cnt=%0d pend=%h required 0/0/0", bus.we_a_o, bus.fifo_count_o, bus.pending_o);
        end
        drive_ex(1'b1, 5'd9, 32'h44);
        drive_lsu(1'b1, 5'd9, 32'h55);
        push_exp(5'd9, 32'h44);
        cyc();
        idle();
        total++;
        if (bus.fifo_count_o !== 2'd1 || bus.pending_o !== 32'h200) begin
            bad++;
            $display("FAIL kill_same_cycle got cnt=%0d pend=%h required 1/00000200", bus.fifo_count_o, bus.pending_o);
        end
        cyc();
        total++;
        if (bus.we_a_o !== 1'b0 || bus.fifo_count_o !== 2'd0) begin
            bad++;
            $display("FAIL kill_same_pop got we=%b cnt=%0d required 0/0", bus.we_a_o, bus.fifo_count_o);
        end
    endtask

    task automatic test_x0();
        for (int i = 0; i < 3; i++) begin
            drive_ex(1'b1, 5'd0, 32'hDEAD_0000 + 32'(i));
            drive_lsu(1'b1, 5'd0, 32'hBEEF_0000 + 32'(i));
            cyc();
            total++;
            if (bus.we_a_o !== 1'b0 || bus.pending_o !== 32'd0 || bus.lsu_ready_o !== 1'b1 || bus.fifo_count_o !== 2'd0) begin
                bad++;
                $display("FAIL x0 got we=%b pend=%h rdy=%b cnt=%0d required 0/0/1/0",
                         bus.we_a_o, bus.pending_o, bus.lsu_ready_o, bus.fifo_count_o);
            end
        end
        idle();
        cyc();
    endtask

    task automatic test_reset_mid();
        drive_ex(1'b1, 5'd1, 32'hC1);
        drive_lsu(1'b1, 5'd8, 32'hC8);
        push_exp(5'd1, 32'hC1);
        cyc();
        drive_ex(1'b1, 5'd2, 32'hC2);
        drive_lsu(1'b1, 5'd9, 32'hC9);
        push_exp(5'd2, 32'hC2);
        cyc();
        idle();
        total++;
        if (bus.fifo_count_o !== 2'd2) begin
            bad++;
            $display("FAIL rst_mid_fill got cnt=%0d required 2", bus.fifo_count_o);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.we_a_o !== 1'b0 || bus.fifo_count_o !== 2'd0 || bus.pending_o !== 32'd0 || bus.lsu_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_async got we=%b cnt=%0d pend=%h rdy=%b required 0/0/0/1",
                     bus.we_a_o, bus.fifo_count_o, bus.pending_o, bus.lsu_ready_o);
        end
        repeat (2) cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++;
            if (bus.we_a_o !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid_stale cycle=%0d got we=%b required 0", i, bus.we_a_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ex_only();
        test_bypass();
        test_queue_full();
        test_kill();
        test_x0();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d outstanding required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
